// File: rtl/eth_pkg.sv
// Shared types and constants for the eth_rx -> eth_tx loopback packet buffer.
package eth_pkg;
    localparam int ETH_MAX_PAYLOAD = 1500;
    localparam int CNT_W           = 16;

    typedef enum logic [2:0] {IDLE, LOAD, STREAM, DONE, GAP} rd_state_e;
endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port byte RAM with registered read; written to map onto block RAM.
module eth_sdp_ram #(
    parameter int gAddr_W = 11
) (
    input  logic               Clk,
    input  logic               we,
    input  logic [gAddr_W-1:0] waddr,
    input  logic [7:0]         wdata,
    input  logic [gAddr_W-1:0] raddr,
    output logic [7:0]         rdata
);
    logic [7:0] mem [2**gAddr_W];

    always_ff @(posedge Clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/eth_rx_pkt_buf.sv
// Store-and-forward frame buffer: speculative byte writes, commit on good frame end,
// replay of committed frames to eth_tx as contiguous bursts followed by a ready pulse.
module eth_rx_pkt_buf
    import eth_pkg::*;
#(
    parameter int gAddr_W     = 11,
    parameter int gPkt_Depth  = 4,
    parameter int gMax_Len    = ETH_MAX_PAYLOAD,
    parameter int gGap_Cycles = 16
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [7:0]         Rx_Byte,
    input  logic               Rx_Byte_Valid,
    input  logic               Rx_Frame_Done,
    input  logic               Rx_Frame_Ok,
    input  logic               Tx_Busy,
    output logic [7:0]         Tx_Byte,
    output logic               Tx_Byte_Valid,
    output logic               Tx_Pkt_Rdy,
    output logic [gAddr_W:0]   Buf_Level,
    output logic [CNT_W-1:0]   Pkt_Count,
    output logic [CNT_W-1:0]   Drop_Count
);
    localparam int DEPTH = 2**gAddr_W;
    localparam int LW    = $clog2(gMax_Len + 1);
    localparam int PW    = $clog2(gPkt_Depth);
    localparam int GW    = $clog2(gGap_Cycles + 1);

    logic [gAddr_W:0]   wr_spec, wr_commit, rd_ptr, spec_now;
    logic [LW-1:0]      frm_len, len_now, rd_rem;
    logic               frame_bad, bad_now, wr_en, commit, fifo_full, fifo_empty;
    logic [LW-1:0]      len_mem [gPkt_Depth];
    logic [PW:0]        lf_wr, lf_rd;
    logic [GW-1:0]      gap_cnt;
    logic [gAddr_W-1:0] rd_addr;
    logic [7:0]         ram_q;
    rd_state_e          state, state_nx;

    // Pointers carry one extra wrap bit so a full buffer is distinguishable from empty.
    assign Buf_Level  = wr_spec - rd_ptr;
    assign wr_en      = Rx_Byte_Valid && !frame_bad && (Buf_Level != (gAddr_W+1)'(DEPTH))
                        && (frm_len < LW'(gMax_Len));
    assign bad_now    = frame_bad || (Rx_Byte_Valid && !wr_en);
    assign len_now    = frm_len + LW'(wr_en);
    assign spec_now   = wr_spec + (gAddr_W+1)'(wr_en);
    assign fifo_full  = (lf_wr - lf_rd) == (PW+1)'(gPkt_Depth);
    assign fifo_empty = (lf_wr == lf_rd);
    assign commit     = Rx_Frame_Done && Rx_Frame_Ok && !bad_now && (len_now != '0) && !fifo_full;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_spec    <= '0;
            wr_commit  <= '0;
            frm_len    <= '0;
            frame_bad  <= 1'b0;
            lf_wr      <= '0;
            Drop_Count <= '0;
        end else if (Rx_Frame_Done) begin
            frm_len   <= '0;
            frame_bad <= 1'b0;
            if (commit) begin
                wr_spec   <= spec_now;
                wr_commit <= spec_now;
                lf_wr     <= lf_wr + (PW+1)'(1);
            end else begin
                wr_spec <= wr_commit;
                if (Drop_Count != '1) Drop_Count <= Drop_Count + CNT_W'(1);
            end
        end else begin
            frm_len   <= len_now;
            frame_bad <= bad_now;
            wr_spec   <= spec_now;
        end
    end

    always_ff @(posedge Clk) begin
        if (commit) len_mem[lf_wr[PW-1:0]] <= len_now;
    end

    eth_sdp_ram #(.gAddr_W(gAddr_W)) u_ram (
        .Clk   (Clk),
        .we    (wr_en),
        .waddr (wr_spec[gAddr_W-1:0]),
        .wdata (Rx_Byte),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    // While streaming, prefetch the next byte so one byte leaves per cycle.
    assign rd_addr = (state == STREAM) ? rd_ptr[gAddr_W-1:0] + gAddr_W'(1) : rd_ptr[gAddr_W-1:0];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!fifo_empty && !Tx_Busy) state_nx = LOAD;
            LOAD:    state_nx = STREAM;
            STREAM:  if (rd_rem == LW'(1)) state_nx = DONE;
            DONE:    state_nx = GAP;
            GAP:     if (gap_cnt == GW'(gGap_Cycles - 1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        Tx_Byte_Valid = (state == STREAM);
        Tx_Pkt_Rdy    = (state == DONE);
        Tx_Byte       = Tx_Byte_Valid ? ram_q : 8'h00;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rd_ptr    <= '0;
            rd_rem    <= '0;
            lf_rd     <= '0;
            gap_cnt   <= '0;
            Pkt_Count <= '0;
        end else begin
            case (state)
                LOAD: begin
                    rd_rem <= len_mem[lf_rd[PW-1:0]];
                    lf_rd  <= lf_rd + (PW+1)'(1);
                end
                STREAM: begin
                    rd_ptr <= rd_ptr + (gAddr_W+1)'(1);
                    rd_rem <= rd_rem - LW'(1);
                end
                DONE: begin
                    Pkt_Count <= Pkt_Count + CNT_W'(1);
                    gap_cnt   <= '0;
                end
                GAP:     gap_cnt <= gap_cnt + GW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_rx_pkt_buf.sv
// Randomised and directed bench for eth_rx_pkt_buf against a frame-level scheduling model.
module tb_eth_rx_pkt_buf;
    localparam int DEPTH = 2048;
    localparam int MAXL  = 1500;
    localparam int PKTD  = 4;
    localparam int GAP   = 16;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [7:0]  Rx_Byte;
    logic        Rx_Byte_Valid, Rx_Frame_Done, Rx_Frame_Ok, Tx_Busy;
    logic [7:0]  Tx_Byte;
    logic        Tx_Byte_Valid, Tx_Pkt_Rdy;
    logic [11:0] Buf_Level;
    logic [15:0] Pkt_Count, Drop_Count;

    // Small instance for buffer-full and pointer-wrap cases.
    logic [7:0]  b_byte, b_tx_byte;
    logic        b_valid, b_done, b_ok, b_busy, b_tx_valid, b_tx_rdy;
    logic [6:0]  b_level;
    logic [15:0] b_pkts, b_drops;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    eth_rx_pkt_buf dut (
        .Clk(Clk), .Rst(Rst), .Rx_Byte(Rx_Byte), .Rx_Byte_Valid(Rx_Byte_Valid),
        .Rx_Frame_Done(Rx_Frame_Done), .Rx_Frame_Ok(Rx_Frame_Ok), .Tx_Busy(Tx_Busy),
        .Tx_Byte(Tx_Byte), .Tx_Byte_Valid(Tx_Byte_Valid), .Tx_Pkt_Rdy(Tx_Pkt_Rdy),
        .Buf_Level(Buf_Level), .Pkt_Count(Pkt_Count), .Drop_Count(Drop_Count)
    );

    eth_rx_pkt_buf #(.gAddr_W(6)) dut_small (
        .Clk(Clk), .Rst(Rst), .Rx_Byte(b_byte), .Rx_Byte_Valid(b_valid),
        .Rx_Frame_Done(b_done), .Rx_Frame_Ok(b_ok), .Tx_Busy(b_busy),
        .Tx_Byte(b_tx_byte), .Tx_Byte_Valid(b_tx_valid), .Tx_Pkt_Rdy(b_tx_rdy),
        .Buf_Level(b_level), .Pkt_Count(b_pkts), .Drop_Count(b_drops)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: committed bytes/lengths as queues, replay timing as a start-cycle schedule.
    logic [7:0] q_bytes[$];
    int         q_lens[$];
    logic [7:0] cur[$];
    bit         cur_bad = 0;
    int cyc = 0, pop_at = -1, act_start = -1, act_len = 0, free_at = 0;
    int pkt_cnt = 0, drop_cnt = 0, commit_unread = 0;
    bit m_ev, m_er;
    logic [7:0] m_eb;
    int m_n, m_lvl;

    always @(negedge Clk) begin
        if (Rst) begin
            chk("rst_tx_valid", Tx_Byte_Valid, 0);
            chk("rst_pkt_rdy", Tx_Pkt_Rdy, 0);
            chk("rst_tx_byte", Tx_Byte, 0);
            chk("rst_level", Buf_Level, 0);
            chk("rst_pkt_count", Pkt_Count, 0);
            chk("rst_drop_count", Drop_Count, 0);
            q_bytes.delete(); q_lens.delete(); cur.delete();
            cur_bad = 0; pop_at = -1; act_start = -1; act_len = 0; free_at = 0;
            pkt_cnt = 0; drop_cnt = 0; commit_unread = 0;
        end else begin
            m_ev  = act_start >= 0 && cyc >= act_start && cyc < act_start + act_len;
            m_er  = act_start >= 0 && cyc == act_start + act_len;
            m_eb  = m_ev ? q_bytes[0] : 8'h00;
            m_lvl = commit_unread + cur.size();
            chk("tx_valid", Tx_Byte_Valid, m_ev);
            if (m_ev) chk("tx_byte", Tx_Byte, m_eb);
            chk("pkt_rdy", Tx_Pkt_Rdy, m_er);
            chk("buf_level", Buf_Level, m_lvl);
            chk("pkt_count", Pkt_Count, 16'(pkt_cnt));
            chk("drop_count", Drop_Count, drop_cnt);
            m_n = q_lens.size();
            if (cyc >= free_at && m_n > 0 && !Tx_Busy) begin
                act_start = cyc + 2;
                act_len   = q_lens[0];
                pop_at    = cyc + 1;
                free_at   = cyc + 3 + act_len + GAP;
            end
            if (Rx_Byte_Valid) begin
                if (!cur_bad && m_lvl < DEPTH && cur.size() < MAXL) cur.push_back(Rx_Byte);
                else cur_bad = 1;
            end
            if (Rx_Frame_Done) begin
                if (Rx_Frame_Ok && !cur_bad && cur.size() > 0 && m_n < PKTD) begin
                    q_lens.push_back(cur.size());
                    foreach (cur[i]) q_bytes.push_back(cur[i]);
                    commit_unread += cur.size();
                end else if (drop_cnt < 65535) drop_cnt++;
                cur.delete();
                cur_bad = 0;
            end
            if (m_ev) begin
                void'(q_bytes.pop_front());
                commit_unread--;
            end
            if (m_er) pkt_cnt++;
            if (cyc == pop_at) void'(q_lens.pop_front());
        end
        cyc++;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_frame(input int len, input bit ok, input bit coinc, input bit rnd,
                              input bit bubbles, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            if (bubbles && $urandom_range(0, 3) == 0) begin
                Rx_Byte_Valid = 1'b0;
                tick();
            end
            Rx_Byte       = rnd ? 8'($urandom) : 8'(base + i);
            Rx_Byte_Valid = 1'b1;
            if (coinc && i == len - 1) begin
                Rx_Frame_Done = 1'b1;
                Rx_Frame_Ok   = ok;
            end
            tick();
        end
        Rx_Byte_Valid = 1'b0;
        if (!coinc) begin
            Rx_Frame_Done = 1'b1;
            Rx_Frame_Ok   = ok;
            tick();
        end
        Rx_Frame_Done = 1'b0;
        Rx_Frame_Ok   = 1'b0;
    endtask

    task automatic wait_drain(input int max, input string name);
        int n = 0;
        while ((q_lens.size() != 0 || cyc < free_at) && n < max) begin
            tick();
            n++;
        end
        chk({name, "_drain_timeout"}, (q_lens.size() == 0 && cyc >= free_at), 1);
    endtask

    task automatic send_small(input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            b_byte  = 8'(base + i);
            b_valid = 1'b1;
            tick();
        end
        b_valid = 1'b0;
        b_done  = 1'b1;
        b_ok    = 1'b1;
        tick();
        b_done  = 1'b0;
        b_ok    = 1'b0;
    endtask

    task automatic drain_small(input int nbytes, input logic [7:0] base, input string name);
        int k = 0;
        bit seen = 0;
        for (int n = 0; n < 300 && !seen; n++) begin
            if (b_tx_valid) begin
                chk({name, "_byte"}, b_tx_byte, 8'(base + k));
                k++;
            end
            if (b_tx_rdy) seen = 1;
            else tick();
        end
        chk({name, "_rdy_seen"}, seen, 1);
        chk({name, "_len"}, k, nbytes);
        chk({name, "_level"}, b_level, 0);
        tick();
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int n;
        Rst = 1'b0;
        Rx_Byte = '0; Rx_Byte_Valid = 0; Rx_Frame_Done = 0; Rx_Frame_Ok = 0; Tx_Busy = 0;
        b_byte = '0; b_valid = 0; b_done = 0; b_ok = 0; b_busy = 1;
        #1 Rst = 1'b1;
        repeat (3) tick();
        Rst = 1'b0;
        tick();

        // Single good frame: latency, content, counters.
        send_frame(64, 1, 0, 0, 0, 8'h00);
        n = 0;
        @(negedge Clk);
        while (!Tx_Byte_Valid && n < 20) begin
            n++;
            @(negedge Clk);
        end
        chk("first_byte_latency", n, 2);
        chk("first_byte_value", Tx_Byte, 8'h00);
        tick();
        wait_drain(500, "good64");
        chk("good64_pkt_count", Pkt_Count, 1);
        chk("good64_level", Buf_Level, 0);

        // Bad CRC then a short good frame.
        send_frame(100, 0, 0, 0, 0, 8'h80);
        send_frame(20, 1, 0, 0, 0, 8'h40);
        wait_drain(500, "badcrc");
        chk("badcrc_drop_count", Drop_Count, 1);
        chk("badcrc_pkt_count", Pkt_Count, 2);

        // Oversize frame, then a maximum-length frame.
        send_frame(1501, 1, 0, 0, 0, 8'h00);
        chk("oversize_drop_count", Drop_Count, 2);
        send_frame(1500, 1, 0, 1, 0, 8'h00);
        wait_drain(5000, "maxlen");
        chk("maxlen_pkt_count", Pkt_Count, 3);

        // Backpressure with a full length FIFO.
        Tx_Busy = 1'b1;
        for (int i = 0; i < 5; i++) send_frame(30, 1, 0, 0, 0, 8'(i * 16));
        chk("queue_drop_count", Drop_Count, 3);
        chk("queue_level", Buf_Level, 120);
        Tx_Busy = 1'b0;
        wait_drain(1000, "queue");
        chk("queue_pkt_count", Pkt_Count, 7);

        // Last byte coincident with frame done.
        send_frame(7, 1, 1, 0, 0, 8'hC0);
        wait_drain(500, "coinc");
        chk("coinc_pkt_count", Pkt_Count, 8);
        chk("coinc_level", Buf_Level, 0);

        // Small buffer: full-buffer drop, drain, then a frame across pointer wrap.
        send_small(60, 8'h00);
        chk("small_level_60", b_level, 60);
        send_small(10, 8'h70);
        chk("small_full_drop", b_drops, 1);
        chk("small_level_after_drop", b_level, 60);
        b_busy = 1'b0;
        drain_small(60, 8'h00, "small_first");
        chk("small_pkt_count_1", b_pkts, 1);
        repeat (25) tick();
        send_small(10, 8'hA0);
        drain_small(10, 8'hA0, "small_wrap");
        chk("small_pkt_count_2", b_pkts, 2);
        chk("small_drop_count", b_drops, 1);

        // Randomised traffic.
        for (int f = 0; f < 40; f++) begin
            Tx_Busy = ($urandom_range(0, 3) == 0);
            send_frame(($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 200),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 1,
                       $urandom_range(0, 1) == 1, 8'h00);
            repeat ($urandom_range(0, 5)) tick();
        end
        Tx_Busy = 1'b0;
        wait_drain(10000, "random");

        // Reset in the middle of a replay with more frames queued.
        Tx_Busy = 1'b1;
        for (int i = 0; i < 3; i++) send_frame(50, 1, 0, 1, 0, 8'h00);
        Tx_Busy = 1'b0;
        n = 0;
        while (!Tx_Byte_Valid && n < 50) begin
            tick();
            n++;
        end
        chk("rst_test_stream_started", Tx_Byte_Valid, 1);
        repeat (5) tick();
        #1 Rst = 1'b1;
        #1;
        chk("async_rst_tx_valid", Tx_Byte_Valid, 0);
        chk("async_rst_tx_byte", Tx_Byte, 0);
        chk("async_rst_level", Buf_Level, 0);
        chk("async_rst_pkt_count", Pkt_Count, 0);
        chk("async_rst_small_level", b_level, 0);
        tick();
        Rst = 1'b0;
        repeat (60) tick();
        chk("post_rst_level", Buf_Level, 0);
        send_frame(16, 1, 0, 0, 0, 8'h10);
        wait_drain(500, "post_rst");
        chk("post_rst_pkt_count", Pkt_Count, 1);
        chk("post_rst_drop_count", Drop_Count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
